vmask_prefix_wb: RTL and testbench
==================================

// Module: vmask_prefix_wb
// PURPOSE
//  Registered result stage directly downstream of the combinational set-before/including/only-first unit.
//  Merges its raw 64-bit result with the old vd per element: body/tail/masked-off policy.
//  Buffers results in a 2-entry FIFO with valid/ready to the SIMD writeback arbiter; 1-cycle latency.
//  Absorbs writeback back-pressure so the combinational stage never holds state.
// PARAMETERS
//  VLEN      128          vector register length in bits (drac_pkg value)
//  MASK_W    VLEN/8       mask elements per register; must be <= 64
//  RD_W      7            physical destination register tag width
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       synchronous reset, active-high
//  flush_i        in   1       kill all buffered entries (branch miss / exception)
//  valid_i        in   1       upstream result valid
//  ready_o        out  1       stage can accept this cycle
//  instr_type_i   in   enum    instr_type_t of the op
//  result_i       in   64      raw result from the set-before/including/only-first unit
//  old_vd_i       in   64      previous contents of destination mask register
//  data_vm_i      in   MASK_W  v0 mask bits
//  use_mask_i     in   1       op is masked (vm=0)
//  vl_i           in   7       active element count, 0..MASK_W
//  rd_i           in   RD_W    destination tag
//  valid_o        out  1       writeback entry valid
//  ready_i        in   1       writeback arbiter accepts
//  data_vd_o      out  64      merged mask result
//  rd_o           out  RD_W    destination tag of head entry
// BEHAVIOUR
//  - Reset/flush: count=0; valid_o=0; ready_o=1; data_vd_o=0; rd_o=0. Flush wins over same-cycle push and pop.
//  - Push = valid_i & ready_o & instr_type_i in {VMSBF,VMSIF,VMSOF}.
//  - valid_i with any other type is consumed and discarded; no output.
//  - Pop = valid_o & ready_i.
//  - Merge at push, per element i < MASK_W:
//    - i >= vl_i -> old_vd_i[i] (tail undisturbed)
//    - else use_mask_i & ~data_vm_i[i] -> old_vd_i[i] (masked-off undisturbed)
//    - else result_i[i]
//  - Merge for bits 63:MASK_W: always 0.
//  - vl_i=0: whole body is tail, so output = old_vd_i[MASK_W-1:0]. vl_i > MASK_W: clamp to MASK_W.
//  - FIFO: 2 entries, states EMPTY(0)/ONE(1)/FULL(2); head/tail 1-bit pointers wrap.
//    - EMPTY: push -> ONE.
//    - ONE: push&pop -> ONE; push only -> FULL; pop only -> EMPTY.
//    - FULL: pop -> ONE.
//  - ready_o = (count != 2), registered from count, not from ready_i (no comb path ready_i -> ready_o).
//  - valid_o = (count != 0). data_vd_o/rd_o come from head entry; stable while valid_o & ~ready_i.
//  - Push to EMPTY is visible on valid_o the next cycle; no bypass. Order is strictly FIFO.
// STRUCTURE
//  - drac_pkg gets: vmask_wb_entry_t {bus64_t data; logic [RD_W-1:0] rd;}.
//  - Merge function is a pure combinational always_comb in this module.
//  - One sub-module: vmask_skid_fifo2 (generic 2-entry valid/ready FIFO of vmask_wb_entry_t, with flush).
//  - VMSBF/VMSIF/VMSOF encodings reused from drac_pkg instr_type_t; no new constants.
// TESTING
//  - Unmasked, vl=16, result=0x00FF, old=0xAAAA, ready_i=1 -> next cycle valid_o=1, data_vd_o=0x00FF.
//  - Masked: vm=0x0F0F, result=0xFFFF, old=0x0000, vl=16 -> data_vd_o=0x0F0F.
//  - Tail: vl=4, result=0xFFFF, old=0x1230 -> data_vd_o=0x123F. vl=0 -> 0x1230.
//  - Back-pressure: ready_i=0, push 3 ops A,B,C back-to-back.
//    - ready_o drops after B; C held upstream.
//    - Raising ready_i drains A,B,C in order with correct rd_o.
//  - Flush while FULL with push pending -> count=0, valid_o=0 next cycle; no stale entry emerges.
//  - Non-prefix type (e.g. VADD) with valid_i=1 -> consumed, valid_o stays 0; rst_i mid-stream clears all.

Source files
------------

// File: rtl/vmask_prefix_wb_pkg.sv
// Shared types for the mask prefix writeback stage: instruction encodings,
// 64-bit bus type, writeback entry and the 2-entry FIFO occupancy states.
package vmask_prefix_wb_pkg;

    localparam int VLEN   = 128;
    localparam int MASK_W = VLEN / 8;
    localparam int RD_W   = 7;

    typedef logic [63:0] bus64_t;

    typedef enum logic [3:0] {
        VADD  = 4'd0,
        VSUB  = 4'd1,
        VMAND = 4'd2,
        VMSBF = 4'd3,
        VMSIF = 4'd4,
        VMSOF = 4'd5
    } instr_type_t;

    typedef struct packed {
        bus64_t            data;
        logic [RD_W-1:0]   rd;
    } vmask_wb_entry_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

    function automatic logic is_prefix_op(input instr_type_t t);
        return (t == VMSBF) || (t == VMSIF) || (t == VMSOF);
    endfunction

endpackage

// File: rtl/vmask_skid_fifo2.sv
// Two-entry FIFO of writeback entries with flush. Occupancy is the FSM state
// and is exposed on state_o; the head entry reads as zero while empty.
module vmask_skid_fifo2
    import vmask_prefix_wb_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  vmask_wb_entry_t data_i,
    output fifo_state_t     state_o,
    output vmask_wb_entry_t data_o
);

    fifo_state_t     state_q, state_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    vmask_wb_entry_t mem_q [2];
    vmask_wb_entry_t mem_d [2];
    logic            do_push, do_pop;

    always_comb begin
        do_push  = push_i & (state_q != FIFO_FULL);
        do_pop   = pop_i & (state_q != FIFO_EMPTY);
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            FIFO_EMPTY: if (do_push) state_d = FIFO_ONE;
            FIFO_ONE: begin
                if (do_push && !do_pop)      state_d = FIFO_FULL;
                else if (!do_push && do_pop) state_d = FIFO_EMPTY;
            end
            FIFO_FULL:  if (do_pop) state_d = FIFO_ONE;
            default:    state_d = FIFO_EMPTY;
        endcase
    end

    // Flush shares the reset path so it always beats a same-cycle push or pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q  <= FIFO_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign state_o = state_q;
    assign data_o  = (state_q == FIFO_EMPTY) ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vmask_prefix_wb.sv
// Registered result stage for set-before/including/only-first: merges the raw
// result with old vd (tail/masked-off undisturbed) and queues it for writeback.
module vmask_prefix_wb
    import vmask_prefix_wb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  instr_type_t       instr_type_i,
    input  bus64_t            result_i,
    input  bus64_t            old_vd_i,
    input  logic [MASK_W-1:0] data_vm_i,
    input  logic              use_mask_i,
    input  logic [6:0]        vl_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              valid_o,
    input  logic              ready_i,
    output bus64_t            data_vd_o,
    output logic [RD_W-1:0]   rd_o
);

    // Handshake: a beat moves on an interface only in a cycle where its valid
    // and ready are both high; ready_o depends on occupancy only, never ready_i.
    fifo_state_t     fifo_state;
    vmask_wb_entry_t push_entry;
    vmask_wb_entry_t head_entry;
    logic            push, pop;
    logic [6:0]      vl_eff;
    bus64_t          merged;
    logic            unused_hi_bits;

    always_comb begin
        vl_eff = (vl_i > 7'(MASK_W)) ? 7'(MASK_W) : vl_i;
        merged = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i >= int'(vl_eff))
                merged[i] = old_vd_i[i];
            else if (use_mask_i && !data_vm_i[i])
                merged[i] = old_vd_i[i];
            else
                merged[i] = result_i[i];
        end
    end

    // Bits above the mask width are forced to zero, so the inputs there are ignored.
    assign unused_hi_bits = ^{result_i[63:MASK_W], old_vd_i[63:MASK_W]};

    assign ready_o         = (fifo_state != FIFO_FULL);
    assign valid_o         = (fifo_state != FIFO_EMPTY);
    assign push            = valid_i & ready_o & is_prefix_op(instr_type_i);
    assign pop             = valid_o & ready_i;
    assign push_entry.data = merged;
    assign push_entry.rd   = rd_i;

    vmask_skid_fifo2 u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_entry),
        .state_o (fifo_state),
        .data_o  (head_entry)
    );

    assign data_vd_o = head_entry.data;
    assign rd_o      = head_entry.rd;

endmodule

// File: tb/tb_vmask_prefix_wb.sv
// Directed bench for vmask_prefix_wb: merge policy, back-pressure ordering,
// flush and reset behaviour, with expected values computed by hand.
module tb_vmask_prefix_wb;
  import vmask_prefix_wb_pkg::*;

  logic              clk;
  logic              rst_i;
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  instr_type_t       instr_type_i;
  bus64_t            result_i;
  bus64_t            old_vd_i;
  logic [MASK_W-1:0] data_vm_i;
  logic              use_mask_i;
  logic [6:0]        vl_i;
  logic [RD_W-1:0]   rd_i;
  logic              valid_o;
  logic              ready_i;
  bus64_t            data_vd_o;
  logic [RD_W-1:0]   rd_o;

  int n_vec;
  int n_bad;
  logic [63:0] exp_q[$];
  logic [63:0] exp_rd_q[$];

  vmask_prefix_wb dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .instr_type_i (instr_type_i),
    .result_i     (result_i),
    .old_vd_i     (old_vd_i),
    .data_vm_i    (data_vm_i),
    .use_mask_i   (use_mask_i),
    .vl_i         (vl_i),
    .rd_i         (rd_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_vd_o    (data_vd_o),
    .rd_o         (rd_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_type_t t, input logic [63:0] res, input logic [63:0] old,
                       input logic [MASK_W-1:0] vm, input logic um, input logic [6:0] vl,
                       input logic [RD_W-1:0] rd);
    valid_i      = 1'b1;
    instr_type_i = t;
    result_i     = res;
    old_vd_i     = old;
    data_vm_i    = vm;
    use_mask_i   = um;
    vl_i         = vl;
    rd_i         = rd;
  endtask

  // push one op through an idle stage with ready_i=1 and check the merged word
  task automatic single(input string tag, input instr_type_t t, input logic [63:0] res,
                        input logic [63:0] old, input logic [MASK_W-1:0] vm, input logic um,
                        input logic [6:0] vl, input logic [RD_W-1:0] rd, input logic [63:0] exp);
    ready_i = 1'b1;
    drive(t, res, old, vm, um, vl, rd);
    step();
    valid_i = 1'b0;
    check({tag, "_valid"}, 64'(valid_o), 64'd1);
    check({tag, "_data"}, data_vd_o, exp);
    check({tag, "_rd"}, 64'(rd_o), 64'(rd));
    step();
    check({tag, "_drained"}, 64'(valid_o), 64'd0);
  endtask

  task automatic check_head(input string tag);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got 0x%0h expected no entry", tag, data_vd_o);
    end else begin
      check({tag, "_data"}, data_vd_o, exp_q[0]);
      check({tag, "_rd"}, 64'(rd_o), exp_rd_q[0]);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_i = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    drive(VADD, '0, '0, '0, 1'b0, 7'd0, '0);
    valid_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_data", data_vd_o, 64'd0);
    check("rst_rd", 64'(rd_o), 64'd0);

    // merge policy
    single("unmasked", VMSBF, 64'h00FF, 64'hAAAA, 16'h0000, 1'b0, 7'd16, 7'd5, 64'h00FF);
    single("masked", VMSIF, 64'hFFFF, 64'h0000, 16'h0F0F, 1'b1, 7'd16, 7'd9, 64'h0F0F);
    single("tail_vl4", VMSOF, 64'hFFFF, 64'h1230, 16'h0000, 1'b0, 7'd4, 7'd10, 64'h123F);
    single("tail_vl0", VMSBF, 64'hFFFF, 64'h1230, 16'h0000, 1'b0, 7'd0, 7'd11, 64'h1230);
    single("vl_clamp", VMSOF, 64'h5555, 64'hFFFF, 16'h0000, 1'b0, 7'd100, 7'd12, 64'h5555);
    single("hi_zero", VMSIF, 64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 1'b0,
           7'd16, 7'd13, 64'h0000);
    single("mask_tail", VMSBF, 64'hFFFF, 64'hA000, 16'h00F0, 1'b1, 7'd8, 7'd14, 64'hA0F0);

    // back-pressure: A, B fill the FIFO, C waits upstream
    ready_i = 1'b0;
    drive(VMSBF, 64'h1111, 64'h0, '0, 1'b0, 7'd16, 7'd1);
    exp_q.push_back(64'h1111); exp_rd_q.push_back(64'd1);
    step();
    check("bp_ready_after_a", 64'(ready_o), 64'd1);
    drive(VMSIF, 64'h2222, 64'h0, '0, 1'b0, 7'd16, 7'd2);
    exp_q.push_back(64'h2222); exp_rd_q.push_back(64'd2);
    step();
    check("bp_ready_after_b", 64'(ready_o), 64'd0);
    check_head("bp_head_a0");
    drive(VMSOF, 64'h3333, 64'h0, '0, 1'b0, 7'd16, 7'd3);
    step();
    check("bp_c_held", 64'(ready_o), 64'd0);
    check_head("bp_head_a_stable");
    ready_i = 1'b1;
    void'(exp_q.pop_front()); void'(exp_rd_q.pop_front());
    step();
    exp_q.push_back(64'h3333); exp_rd_q.push_back(64'd3);
    check("bp_ready_back", 64'(ready_o), 64'd1);
    check_head("bp_head_b");
    void'(exp_q.pop_front()); void'(exp_rd_q.pop_front());
    step();
    valid_i = 1'b0;
    check_head("bp_head_c");
    void'(exp_q.pop_front()); void'(exp_rd_q.pop_front());
    step();
    check("bp_empty", 64'(valid_o), 64'd0);
    check("bp_queue_drained", 64'(exp_q.size()), 64'd0);

    // flush while FULL with push and pop pending
    ready_i = 1'b0;
    drive(VMSBF, 64'h4444, 64'h0, '0, 1'b0, 7'd16, 7'd4);
    step();
    drive(VMSBF, 64'h5555, 64'h0, '0, 1'b0, 7'd16, 7'd5);
    step();
    check("fl_full", 64'(ready_o), 64'd0);
    drive(VMSIF, 64'h6666, 64'h0, '0, 1'b0, 7'd16, 7'd6);
    ready_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("fl_valid", 64'(valid_o), 64'd0);
    check("fl_ready", 64'(ready_o), 64'd1);
    check("fl_data", data_vd_o, 64'd0);
    step();
    check("fl_no_stale", 64'(valid_o), 64'd0);

    // flush beats a push into a one-entry FIFO
    ready_i = 1'b0;
    drive(VMSOF, 64'h7777, 64'h0, '0, 1'b0, 7'd16, 7'd7);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("fl1_valid", 64'(valid_o), 64'd0);
    step();
    check("fl1_still_empty", 64'(valid_o), 64'd0);

    // non-prefix op is consumed without output
    ready_i = 1'b1;
    drive(VADD, 64'hFFFF, 64'h0, '0, 1'b0, 7'd16, 7'd8);
    check("vadd_accepted", 64'(ready_o), 64'd1);
    step();
    valid_i = 1'b0;
    check("vadd_no_out", 64'(valid_o), 64'd0);
    step();
    check("vadd_no_out2", 64'(valid_o), 64'd0);

    // reset mid-stream
    ready_i = 1'b0;
    drive(VMSBF, 64'h00AA, 64'h0, '0, 1'b0, 7'd16, 7'd15);
    step();
    check("mid_pre_valid", 64'(valid_o), 64'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    valid_i = 1'b0;
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    check("mid_rst_data", data_vd_o, 64'd0);
    check("mid_rst_rd", 64'(rd_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
